// File: rtl/flit_injector_pkg.sv
// -----------------------------------------------------------------------------
// flit_injector_pkg -- local types of the flit injector.
// Holds only the injector FSM state encoding; every NoC-wide type and width
// comes from noc_params.
// -----------------------------------------------------------------------------
package flit_injector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ALLOC   = 2'b01,
        ST_HEAD    = 2'b10,
        ST_PAYLOAD = 2'b11
    } inj_state_t;

endpackage

// File: rtl/noc_params.sv
// -----------------------------------------------------------------------------
// noc_params -- shared NoC parameters and flit types.
// Provides the virtual-channel count, the address, payload and data widths,
// the flit label enum and the packed flit_t structure used at router ports.
// Head flits carry the destination and the head payload; body and tail flits
// carry a raw payload of the same width.
// -----------------------------------------------------------------------------
package noc_params;

    localparam int VC_NUM            = 4;
    localparam int VC_SIZE           = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
    localparam int DEST_ADDR_SIZE_X  = 4;
    localparam int DEST_ADDR_SIZE_Y  = 4;
    localparam int HEAD_PAYLOAD_SIZE = 16;
    localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t        flit_label;
        logic [VC_SIZE-1:0] vc_id;
        flit_data_t         data;
    } flit_t;

endpackage

// File: rtl/flit_injector_vc_picker.sv
// -----------------------------------------------------------------------------
// vc_picker -- combinational virtual-channel selector.
// Searches the allocatable mask starting at start_ptr_i and wrapping modulo
// VC_NUM; the first set bit found is granted.
// Ports:
//   alloc_mask_i   in  VC_NUM   per-VC "free for a new packet"
//   start_ptr_i    in  VC_SIZE  index the search starts from
//   grant_o        out VC_NUM   one-hot grant (all zero when nothing is free)
//   grant_valid_o  out 1        at least one VC was granted
// -----------------------------------------------------------------------------
module vc_picker
    import noc_params::*;
(
    input  logic [VC_NUM-1:0]  alloc_mask_i,
    input  logic [VC_SIZE-1:0] start_ptr_i,
    output logic [VC_NUM-1:0]  grant_o,
    output logic               grant_valid_o
);

    logic [VC_SIZE-1:0] w_idx;

    // Rotating first-set search over the allocatable mask
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        w_idx         = '0;
        for (int k = 0; k < VC_NUM; k++) begin
            w_idx = VC_SIZE'((int'(start_ptr_i) + k) % VC_NUM);
            if (!grant_valid_o && alloc_mask_i[w_idx]) begin
                grant_o[w_idx] = 1'b1;
                grant_valid_o  = 1'b1;
            end else begin
                grant_valid_o  = grant_valid_o;
            end
        end
    end

endmodule

// File: rtl/flit_injector.sv
// -----------------------------------------------------------------------------
// flit_injector -- turns packet requests from a core into a flit stream for a
// router input port.
// A request (destination, head payload, length) is accepted in IDLE, a free
// virtual channel is allocated, the head flit is sent, then body/tail flits
// are taken from the payload stream. Flits are only issued while the
// downstream on/off credit of the chosen VC is high; the VC is held for the
// whole packet.
// Ports:
//   clk, rst                         clock, asynchronous active-low reset
//   pkt_valid_i / pkt_ready_o        packet request handshake
//   pkt_dest_x_i, pkt_dest_y_i       destination coordinates
//   pkt_head_pl_i                    head-flit payload
//   pkt_len_i                        packet length in flits (0 -> 1, clamped)
//   pld_valid_i/pld_ready_o/pld_data_i  body/tail payload stream
//   data_o, is_valid_o               registered flit output
//   is_on_off_i, is_allocatable_i    per-VC downstream status
// Configuration macro:
//   FLIT_INJECTOR_RR_VC_EN  defined: round-robin VC choice starting after the
//                           last granted VC; undefined: lowest free VC wins.
// -----------------------------------------------------------------------------
module flit_injector
    import noc_params::*;
    import flit_injector_pkg::*;
#(
    parameter int MAX_PKT_FLITS = 8,
    parameter int LEN_W         = $clog2(MAX_PKT_FLITS) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid_i,
    output logic                         pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_dest_x_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_dest_y_i,
    input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
    input  logic [LEN_W-1:0]             pkt_len_i,
    input  logic                         pld_valid_i,
    output logic                         pld_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]    pld_data_i,
    output flit_t                        data_o,
    output logic                         is_valid_o,
    input  logic [VC_NUM-1:0]            is_on_off_i,
    input  logic [VC_NUM-1:0]            is_allocatable_i
);

    // Zero-length requests become single-flit packets; oversize ones are clamped
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len_in);
        logic [LEN_W-1:0] v;
        if (len_in == '0) begin
            v = LEN_W'(1);
        end else if (len_in > LEN_W'(MAX_PKT_FLITS)) begin
            v = LEN_W'(MAX_PKT_FLITS);
        end else begin
            v = len_in;
        end
        return v;
    endfunction

    inj_state_t                   r_state;
    logic [DEST_ADDR_SIZE_X-1:0]  r_dest_x;
    logic [DEST_ADDR_SIZE_Y-1:0]  r_dest_y;
    logic [HEAD_PAYLOAD_SIZE-1:0] r_head_pl;
    logic [LEN_W-1:0]             r_len;
    logic [LEN_W-1:0]             r_cnt;
    logic [VC_SIZE-1:0]           r_cur_vc;
    flit_t                        r_data;
    logic                         r_valid;

    logic [VC_SIZE-1:0]           w_start_ptr;
    logic [VC_NUM-1:0]            w_grant;
    logic                         w_grant_valid;
    logic [VC_SIZE-1:0]           w_grant_idx;
    logic                         w_on;
    flit_t                        w_head_flit;
    flit_t                        w_pld_flit;

`ifdef FLIT_INJECTOR_RR_VC_EN
    logic [VC_SIZE-1:0]           r_rr_ptr;
    logic [VC_SIZE-1:0]           w_rr_next;

    assign w_start_ptr = r_rr_ptr;
    assign w_rr_next   = (w_grant_idx == VC_SIZE'(VC_NUM - 1)) ? '0 : w_grant_idx + VC_SIZE'(1);

    // Round-robin pointer: next search starts one past the VC just granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (r_state == ST_ALLOC && w_grant_valid) begin
            r_rr_ptr <= w_rr_next;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`else
    assign w_start_ptr = '0;
`endif

    vc_picker u_vc_picker (
        .alloc_mask_i  (is_allocatable_i),
        .start_ptr_i   (w_start_ptr),
        .grant_o       (w_grant),
        .grant_valid_o (w_grant_valid)
    );

    // One-hot grant to VC index
    always_comb begin
        w_grant_idx = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (w_grant[v]) begin
                w_grant_idx = VC_SIZE'(v);
            end else begin
                w_grant_idx = w_grant_idx;
            end
        end
    end

    assign w_on = is_on_off_i[r_cur_vc];

    // Candidate head and payload flits for the current packet
    always_comb begin
        w_head_flit                        = '0;
        w_head_flit.flit_label             = (r_len == LEN_W'(1)) ? HEADTAIL : HEAD;
        w_head_flit.vc_id                  = r_cur_vc;
        w_head_flit.data.head_data.x_dest  = r_dest_x;
        w_head_flit.data.head_data.y_dest  = r_dest_y;
        w_head_flit.data.head_data.head_pl = r_head_pl;

        w_pld_flit                         = '0;
        w_pld_flit.flit_label              = (r_cnt == LEN_W'(1)) ? TAIL : BODY;
        w_pld_flit.vc_id                   = r_cur_vc;
        w_pld_flit.data.bt_pl              = pld_data_i;
    end

    // Injector FSM with registered flit output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_dest_x  <= '0;
            r_dest_y  <= '0;
            r_head_pl <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_cur_vc  <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (pkt_valid_i) begin
                        r_dest_x  <= pkt_dest_x_i;
                        r_dest_y  <= pkt_dest_y_i;
                        r_head_pl <= pkt_head_pl_i;
                        r_len     <= clamp_len(pkt_len_i);
                        r_state   <= ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (w_grant_valid) begin
                        r_cur_vc <= w_grant_idx;
                        r_state  <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    if (w_on) begin
                        r_data  <= w_head_flit;
                        r_valid <= 1'b1;
                        r_cnt   <= r_len - LEN_W'(1);
                        r_state <= (r_len == LEN_W'(1)) ? ST_IDLE : ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_on && pld_valid_i) begin
                        r_data  <= w_pld_flit;
                        r_valid <= 1'b1;
                        r_cnt   <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready signals must react in the same cycle the credit changes, so they
    // are decoded from registered state rather than registered themselves.
    assign pkt_ready_o = rst && (r_state == ST_IDLE);
    assign pld_ready_o = (r_state == ST_PAYLOAD) && w_on;
    assign data_o      = r_data;
    assign is_valid_o  = r_valid;

endmodule

// File: tb/tb_flit_injector.sv
// -----------------------------------------------------------------------------
// tb_flit_injector -- directed self-checking bench for flit_injector.
// Expected VC ids depend on FLIT_INJECTOR_RR_VC_EN.
// -----------------------------------------------------------------------------
module tb_flit_injector;
    import noc_params::*;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic                         pkt_valid_i = 1'b0;
    logic                         pkt_ready_o;
    logic [DEST_ADDR_SIZE_X-1:0]  pkt_dest_x_i = '0;
    logic [DEST_ADDR_SIZE_Y-1:0]  pkt_dest_y_i = '0;
    logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i = '0;
    logic [3:0]                   pkt_len_i = '0;
    logic                         pld_valid_i = 1'b0;
    logic                         pld_ready_o;
    logic [FLIT_DATA_SIZE-1:0]    pld_data_i = '0;
    flit_t                        data_o;
    logic                         is_valid_o;
    logic [VC_NUM-1:0]            is_on_off_i = '0;
    logic [VC_NUM-1:0]            is_allocatable_i = '0;

    int total = 0;
    int bad   = 0;

`ifdef FLIT_INJECTOR_RR_VC_EN
    localparam logic [1:0] T2_VC = 2'd1;
    localparam logic [1:0] T3_VC = 2'd2;
    localparam logic [1:0] T6_VC = 2'd3;
    localparam logic [1:0] T7_VC = 2'd3;
    localparam bit         RR_ON = 1'b1;
`else
    localparam logic [1:0] T2_VC = 2'd0;
    localparam logic [1:0] T3_VC = 2'd0;
    localparam logic [1:0] T6_VC = 2'd0;
    localparam logic [1:0] T7_VC = 2'd0;
    localparam bit         RR_ON = 1'b0;
`endif

    flit_injector dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid_i      (pkt_valid_i),
        .pkt_ready_o      (pkt_ready_o),
        .pkt_dest_x_i     (pkt_dest_x_i),
        .pkt_dest_y_i     (pkt_dest_y_i),
        .pkt_head_pl_i    (pkt_head_pl_i),
        .pkt_len_i        (pkt_len_i),
        .pld_valid_i      (pld_valid_i),
        .pld_ready_o      (pld_ready_o),
        .pld_data_i       (pld_data_i),
        .data_o           (data_o),
        .is_valid_o       (is_valid_o),
        .is_on_off_i      (is_on_off_i),
        .is_allocatable_i (is_allocatable_i)
    );

    always #5 clk = ~clk;

    function automatic flit_t mk_head(input flit_label_t l, input logic [1:0] vc,
                                      input logic [3:0] x, input logic [3:0] y,
                                      input logic [15:0] pl);
        flit_t f;
        f = '0;
        f.flit_label             = l;
        f.vc_id                  = vc;
        f.data.head_data.x_dest  = x;
        f.data.head_data.y_dest  = y;
        f.data.head_data.head_pl = pl;
        return f;
    endfunction

    function automatic flit_t mk_bt(input flit_label_t l, input logic [1:0] vc,
                                    input logic [23:0] d);
        flit_t f;
        f = '0;
        f.flit_label = l;
        f.vc_id      = vc;
        f.data.bt_pl = d;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_pkt(input logic [3:0] x, input logic [3:0] y,
                             input logic [15:0] pl, input logic [3:0] len);
        pkt_valid_i   = 1'b1;
        pkt_dest_x_i  = x;
        pkt_dest_y_i  = y;
        pkt_head_pl_i = pl;
        pkt_len_i     = len;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid",    32'(is_valid_o),  32'd0);
        chk("rst_data",     32'(data_o),      32'd0);
        chk("rst_pkt_rdy",  32'(pkt_ready_o), 32'd0);
        chk("rst_pld_rdy",  32'(pld_ready_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("idle_pkt_rdy", 32'(pkt_ready_o), 32'd1);

        // 4-flit packet on a free, on VC
        is_allocatable_i = 4'hF;
        is_on_off_i      = 4'hF;
        start_pkt(4'd3, 4'd5, 16'hBEEF, 4'd4);
        pld_valid_i = 1'b1;
        pld_data_i  = 24'h00000A;
        tick();
        pkt_valid_i = 1'b0;
        chk("t1_busy",       32'(pkt_ready_o), 32'd0);
        chk("t1_pldrdy_alc", 32'(pld_ready_o), 32'd0);
        chk("t1_nv_alloc",   32'(is_valid_o),  32'd0);
        tick();
        chk("t1_nv_head",    32'(is_valid_o),  32'd0);
        chk("t1_pldrdy_hd",  32'(pld_ready_o), 32'd0);
        tick();
        chk("t1_head_v",     32'(is_valid_o),  32'd1);
        chk("t1_head",       32'(data_o), 32'(mk_head(HEAD, 2'd0, 4'd3, 4'd5, 16'hBEEF)));
        chk("t1_pldrdy",     32'(pld_ready_o), 32'd1);
        tick();
        chk("t1_body_a",     32'(data_o), 32'(mk_bt(BODY, 2'd0, 24'h00000A)));
        pld_data_i = 24'h00000B;
        tick();
        chk("t1_body_b",     32'(data_o), 32'(mk_bt(BODY, 2'd0, 24'h00000B)));
        pld_data_i = 24'h00000C;
        tick();
        chk("t1_tail_v",     32'(is_valid_o),  32'd1);
        chk("t1_tail_c",     32'(data_o), 32'(mk_bt(TAIL, 2'd0, 24'h00000C)));
        chk("t1_rdy_again",  32'(pkt_ready_o), 32'd1);
        tick();
        chk("t1_idle_nv",    32'(is_valid_o),  32'd0);
        chk("t1_hold",       32'(data_o), 32'(mk_bt(TAIL, 2'd0, 24'h00000C)));
        pld_valid_i = 1'b0;

        // Single-flit packet
        start_pkt(4'd1, 4'd2, 16'h1234, 4'd1);
        tick();
        pkt_valid_i = 1'b0;
        tick();
        tick();
        chk("t2_ht_v",   32'(is_valid_o), 32'd1);
        chk("t2_ht",     32'(data_o), 32'(mk_head(HEADTAIL, T2_VC, 4'd1, 4'd2, 16'h1234)));
        chk("t2_rdy",    32'(pkt_ready_o), 32'd1);
        tick();
        chk("t2_nv",     32'(is_valid_o), 32'd0);

        // Credit stall for 3 cycles after the head
        start_pkt(4'd7, 4'd0, 16'h5555, 4'd3);
        tick();
        pkt_valid_i = 1'b0;
        tick();
        tick();
        chk("t3_head", 32'(data_o), 32'(mk_head(HEAD, T3_VC, 4'd7, 4'd0, 16'h5555)));
        is_on_off_i = 4'hF & ~(4'b0001 << T3_VC);
        pld_valid_i = 1'b1;
        pld_data_i  = 24'hD0D0D0;
        #1;
        chk("t3_stall_rdy0", 32'(pld_ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_stall_nv",  32'(is_valid_o),  32'd0);
            chk("t3_stall_rdy", 32'(pld_ready_o), 32'd0);
        end
        is_on_off_i = 4'hF;
        #1;
        chk("t3_resume_rdy", 32'(pld_ready_o), 32'd1);
        tick();
        chk("t3_body", 32'(data_o), 32'(mk_bt(BODY, T3_VC, 24'hD0D0D0)));
        pld_data_i = 24'hE0E0E0;
        tick();
        chk("t3_tail", 32'(data_o), 32'(mk_bt(TAIL, T3_VC, 24'hE0E0E0)));
        pld_valid_i = 1'b0;

        // No VC allocatable for 5 cycles, then only VC2
        is_allocatable_i = 4'h0;
        start_pkt(4'd2, 4'd2, 16'hA5A5, 4'd1);
        tick();
        pkt_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold_nv",  32'(is_valid_o),  32'd0);
            chk("t4_hold_rdy", 32'(pkt_ready_o), 32'd0);
        end
        is_allocatable_i = 4'b0100;
        tick();
        chk("t4_nv", 32'(is_valid_o), 32'd0);
        tick();
        chk("t4_ht", 32'(data_o), 32'(mk_head(HEADTAIL, 2'd2, 4'd2, 4'd2, 16'hA5A5)));
        is_allocatable_i = 4'hF;

        // Reset in the middle of a 6-flit packet
        start_pkt(4'd4, 4'd4, 16'h6666, 4'd6);
        tick();
        pkt_valid_i = 1'b0;
        tick();
        tick();
        chk("t6_head", 32'(data_o), 32'(mk_head(HEAD, T6_VC, 4'd4, 4'd4, 16'h6666)));
        pld_valid_i = 1'b1;
        pld_data_i  = 24'h000111;
        tick();
        chk("t6_body", 32'(data_o), 32'(mk_bt(BODY, T6_VC, 24'h000111)));
        rst = 1'b0;
        #1;
        chk("t6_rst_nv",   32'(is_valid_o),  32'd0);
        chk("t6_rst_data", 32'(data_o),      32'd0);
        chk("t6_rst_pld",  32'(pld_ready_o), 32'd0);
        chk("t6_rst_pkt",  32'(pkt_ready_o), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_idle",     32'(pkt_ready_o), 32'd1);
        chk("t6_no_tail",  32'(is_valid_o),  32'd0);
        pld_valid_i = 1'b0;

        // Three back-to-back single-flit packets; the last has length 0
        for (int i = 0; i < 3; i++) begin
            start_pkt(4'(i), 4'(i), 16'(16'h0100 + i), (i == 2) ? 4'd0 : 4'd1);
            tick();
            pkt_valid_i = 1'b0;
            tick();
            tick();
            chk("t5_ht", 32'(data_o),
                32'(mk_head(HEADTAIL, RR_ON ? 2'(i) : 2'd0, 4'(i), 4'(i), 16'(16'h0100 + i))));
            chk("t5_rdy", 32'(pkt_ready_o), 32'd1);
        end

        // Length 12 clamps to 8 flits
        start_pkt(4'd9, 4'd9, 16'hC1A0, 4'd12);
        pld_valid_i = 1'b1;
        pld_data_i  = 24'd1;
        tick();
        pkt_valid_i = 1'b0;
        tick();
        tick();
        chk("t7_head", 32'(data_o), 32'(mk_head(HEAD, T7_VC, 4'd9, 4'd9, 16'hC1A0)));
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("t7_pld", 32'(data_o), 32'(mk_bt((i == 7) ? TAIL : BODY, T7_VC, 24'(i))));
            pld_data_i = 24'(i + 1);
        end
        tick();
        chk("t7_end_nv", 32'(is_valid_o), 32'd0);
        pld_valid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flit_injector.md
FLIT_INJECTOR -- requirements
Module: flit_injector

Interface
REQ-001 Parameter MAX_PKT_FLITS, default 8, maximum flits per packet, including the head flit.
REQ-002 Parameter LEN_W, default $clog2(MAX_PKT_FLITS)+1, width of the packet-length input.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 pkt_valid_i  in  1  packet request from the core.
REQ-006 pkt_ready_o  out  1  injector can accept a packet request.
REQ-007 pkt_dest_x_i / pkt_dest_y_i  in  DEST_ADDR_SIZE_X / DEST_ADDR_SIZE_Y  destination coordinates.
REQ-008 pkt_head_pl_i  in  HEAD_PAYLOAD_SIZE  head-flit payload.
REQ-009 pkt_len_i  in  LEN_W  packet length in flits.
REQ-010 pld_valid_i / pld_ready_o / pld_data_i  in / out / in  1 / 1 / FLIT_DATA_SIZE  body and tail payload stream.
REQ-011 data_o  out  flit_t  flit toward the router input port.
REQ-012 is_valid_o  out  1  data_o carries a flit this cycle.
REQ-013 is_on_off_i  in  VC_NUM  per-VC on/off credit from downstream.
REQ-014 is_allocatable_i  in  VC_NUM  per-VC "free for a new packet" from downstream.

Function
REQ-015 FSM states: IDLE, ALLOC, HEAD, PAYLOAD.
REQ-016 IDLE: pkt_ready_o=1; when pkt_valid_i=1, register destination, head payload and length, then go to ALLOC.
REQ-017 Length handling: pkt_len_i=0 is treated as 1; values above MAX_PKT_FLITS are clamped to MAX_PKT_FLITS.
REQ-018 ALLOC: select a VC v with is_allocatable_i[v]=1 and register it as cur_vc, then go to HEAD; if no VC is allocatable, stay in ALLOC.
REQ-019 HEAD: when is_on_off_i[cur_vc]=1, issue the head flit (label HEAD, or HEADTAIL if length=1; vc_id=cur_vc; destination and head payload); go to IDLE if length=1, else PAYLOAD.
REQ-020 PAYLOAD: when is_on_off_i[cur_vc]=1 and pld_valid_i=1, assert pld_ready_o and issue one flit with payload pld_data_i, label BODY or TAIL (last flit), vc_id=cur_vc.
REQ-021 pld_ready_o shall be 0 in every state other than PAYLOAD and whenever is_on_off_i[cur_vc]=0.
REQ-022 Flit counter: loaded with length-1 on the head flit, decremented on each payload flit; the flit issued when the count reaches 1 is TAIL; after TAIL, go to IDLE.
REQ-023 data_o and is_valid_o are registered: a flit issued in cycle N appears with is_valid_o=1 in cycle N+1 for exactly one cycle.
REQ-024 When no flit is issued, is_valid_o=0 and data_o holds its previous value.
REQ-025 Latency with a free VC and on=1: accept edge N, ALLOC N+1, head issued N+2, head visible on is_valid_o at N+3; then one flit per cycle while on=1 and pld_valid_i=1.
REQ-026 Only one packet is outstanding: pkt_ready_o=0 from ALLOC until after TAIL or HEADTAIL is issued.
REQ-027 is_on_off_i dropping mid-packet: stall, and resume on the same cur_vc; the VC is never changed inside a packet.

Reset
REQ-028 On rst=0, asynchronously: state=IDLE, is_valid_o=0, data_o=0, pld_ready_o=0, counter=0, cur_vc=0, round-robin pointer=0.
REQ-029 pkt_ready_o shall be 0 while rst=0.
REQ-030 Reset asserted mid-packet drops the partial packet; no TAIL is emitted.

Configuration
REQ-031 Macro FLIT_INJECTOR_RR_VC_EN defined: ALLOC picks the first allocatable VC at or after (last granted VC + 1) modulo VC_NUM; the pointer updates on each grant.
REQ-032 Macro FLIT_INJECTOR_RR_VC_EN undefined: ALLOC picks the lowest-index allocatable VC; no pointer register is built.

Structure
REQ-033 flit_t, flit label enum, VC_NUM, DEST_ADDR_SIZE_X/Y, HEAD_PAYLOAD_SIZE and FLIT_DATA_SIZE come from noc_params; no new package constants.
REQ-034 VC selection is a sub-module, vc_picker (combinational: allocatable mask plus start pointer in, one-hot grant and valid out).

Verification
REQ-035 VCs 0..3 allocatable and on, pkt_len_i=4 with payloads A,B,C -> HEAD(vc0), BODY A, BODY B, TAIL C on consecutive cycles; head visible 3 cycles after accept.
REQ-036 pkt_len_i=1 -> single HEADTAIL flit; pkt_ready_o=1 again on the following cycle.
REQ-037 is_on_off_i[cur_vc] low for 3 cycles after the head -> no flits and pld_ready_o=0 for 3 cycles, then BODY resumes on the same vc_id.
REQ-038 is_allocatable_i=0 for 5 cycles then 4'b0100 -> FSM holds in ALLOC, and the head flit uses vc_id=2.
REQ-039 With FLIT_INJECTOR_RR_VC_EN and all VCs free, 3 back-to-back packets -> vc_id 0, 1, 2; without the macro -> 0, 0, 0.
REQ-040 Reset pulse during a 6-flit packet after the 2nd flit -> is_valid_o=0 immediately, state IDLE, no TAIL; the next packet proceeds normally.
